// File: rtl/mult_hilo_seq.sv
// mult_hilo_seq
//
// Sequential multiply unit that produces the full 2*WIDTH-bit product
// for mult (signed) and multu (unsigned). The result goes into the
// architectural HI/LO registers. It uses an iterative shift-add datapath
// that handles one multiplier bit per cycle.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   start      begin a multiply (sampled only in IDLE)
//   is_signed  1 = two's-complement operands, 0 = unsigned (latched with start)
//   a, b       multiplicand / multiplier (latched with start)
//   mthi/mtlo  write hi_wdata/lo_wdata into HI/LO (honoured only in IDLE)
//   hi_wdata   data for mthi
//   lo_wdata   data for mtlo
//   busy       high whenever the unit is not IDLE
//   done       one-cycle pulse in the cycle HI/LO take a new product
//   hi, lo     architectural HI/LO registers

module mult_hilo_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FINISH
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs. FINISH counts as busy so the
    // control unit keeps stalling until HI/LO actually hold the product.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The multiplication runs on magnitudes and the sign is applied at
    // the end. Negating the most negative value wraps back to itself.
    // Read as unsigned, that is the correct magnitude.
    // The adder keeps its carry-out bit. That bit is shifted into the top
    // of the accumulator, so unsigned operands at full range cannot
    // overflow.
    always_comb begin
        a_mag   = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag   = (is_signed && b[WIDTH-1]) ? -b : b;
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
        product = neg ? -acc : acc;
    end

    // Datapath and HI/LO registers. mthi/mtlo are accepted only in IDLE.
    // When they arrive together with start, the write lands now and the
    // product overwrites it later at FINISH.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            count  <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                    end
                    if (mthi) begin
                        hi <= hi_wdata;
                    end
                    if (mtlo) begin
                        lo <= lo_wdata;
                    end
                end
                BUSY: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                end
                FINISH: begin
                    hi <= product[2*WIDTH-1:WIDTH];
                    lo <= product[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_seq.sv
// tb_mult_hilo_seq
//
// Directed testbench for mult_hilo_seq (WIDTH=32). It checks the reset
// state, mthi/mtlo, aborting with reset mid-operation, the signed and
// unsigned corner products, and that start/mthi/mtlo are ignored while
// busy. It also runs back-to-back operations and a random sweep against a
// 64-bit reference product.

module tb_mult_hilo_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int passes;

    mult_hilo_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .hi_wdata  (hi_wdata),
        .lo_wdata  (lo_wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: count it, report on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference 64-bit product.
    function automatic logic [63:0] refProd(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = sgn ? {{32{x[31]}}, x} : {32'b0, x};
        ye = sgn ? {{32{y[31]}}, y} : {32'b0, y};
        return xe * ye;
    endfunction

    // Run one multiply from an IDLE cycle and check the timing and result.
    // interfere: pulse start with other operands at cycles 5 and 20, and
    // try mthi/mtlo at cycle 10.
    // wr_with_start: assert mthi/mtlo together with start.
    task automatic applyStimulus(input string tag, input logic sgn,
                                 input logic [31:0] ea, input logic [31:0] eb,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                 input bit interfere, input bit wr_with_start);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int          busy_bad;
        int          done_bad;
        is_signed = sgn;
        a         = ea;
        b         = eb;
        start     = 1'b1;
        if (wr_with_start) begin
            mthi     = 1'b1;
            mtlo     = 1'b1;
            hi_wdata = 32'hDEADBEEF;
            lo_wdata = 32'hCAFEF00D;
        end
        step();
        start     = 1'b0;
        mthi      = 1'b0;
        mtlo      = 1'b0;
        a         = ~ea;
        b         = ~eb;
        is_signed = ~sgn;
        if (wr_with_start) begin
            checkOutput({tag, " hi_write_with_start"}, {32'b0, hi}, {32'b0, 32'hDEADBEEF});
            checkOutput({tag, " lo_write_with_start"}, {32'b0, lo}, {32'b0, 32'hCAFEF00D});
        end
        prev_hi  = hi;
        prev_lo  = lo;
        busy_bad = 0;
        done_bad = 0;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            if (busy !== 1'b1) busy_bad++;
            if (done !== 1'b0) done_bad++;
            if (interfere && (cyc == 5 || cyc == 20)) begin
                start     = 1'b1;
                a         = 32'd100;
                b         = 32'd200;
                is_signed = 1'b1;
            end
            if (interfere && cyc == 10) begin
                mthi     = 1'b1;
                mtlo     = 1'b1;
                hi_wdata = 32'h12345678;
                lo_wdata = 32'h9ABCDEF0;
            end
            step();
            start = 1'b0;
            mthi  = 1'b0;
            mtlo  = 1'b0;
        end
        // Cycle 33: FINISH.
        checkOutput({tag, " busy_cycles_1_32"}, 64'(busy_bad), 64'd0);
        checkOutput({tag, " done_early"},       64'(done_bad), 64'd0);
        checkOutput({tag, " done_cycle33"},     {63'b0, done}, 64'd1);
        checkOutput({tag, " busy_cycle33"},     {63'b0, busy}, 64'd1);
        checkOutput({tag, " hilo_hold"},        {hi, lo}, {prev_hi, prev_lo});
        step();
        // Cycle 34: back in IDLE with the product.
        checkOutput({tag, " done_pulse_end"},   {63'b0, done}, 64'd0);
        checkOutput({tag, " busy_idle"},        {63'b0, busy}, 64'd0);
        checkOutput({tag, " hi"},               {32'b0, hi}, {32'b0, exp_hi});
        checkOutput({tag, " lo"},               {32'b0, lo}, {32'b0, exp_lo});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] rp;
        logic [31:0] rlo;
        int          done_seen;

        checks    = 0;
        passes    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        mthi      = 1'b0;
        mtlo      = 1'b0;
        hi_wdata  = '0;
        lo_wdata  = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state.
        checkOutput("reset busy", {63'b0, busy}, 64'd0);
        checkOutput("reset done", {63'b0, done}, 64'd0);
        checkOutput("reset hilo", {hi, lo}, 64'd0);

        // mthi/mtlo in IDLE.
        mthi     = 1'b1;
        mtlo     = 1'b1;
        hi_wdata = 32'h12345678;
        lo_wdata = 32'h9ABCDEF0;
        step();
        mthi = 1'b0;
        mtlo = 1'b0;
        checkOutput("mthi idle", {32'b0, hi}, {32'b0, 32'h12345678});
        checkOutput("mtlo idle", {32'b0, lo}, {32'b0, 32'h9ABCDEF0});
        step();
        checkOutput("hilo hold idle", {hi, lo}, 64'h12345678_9ABCDEF0);

        // Reset mid-operation: start at edge 0, reset sampled at edge 10.
        is_signed = 1'b0;
        a         = 32'd7;
        b         = 32'd9;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort busy", {63'b0, busy}, 64'd0);
        checkOutput("abort done", {63'b0, done}, 64'd0);
        checkOutput("abort hilo", {hi, lo}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0) done_seen++;
            step();
        end
        checkOutput("abort no_done", 64'(done_seen), 64'd0);
        checkOutput("abort hilo_later", {hi, lo}, 64'd0);
        applyStimulus("after_abort", 1'b0, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, 1'b0);

        // Directed products.
        applyStimulus("umax",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        applyStimulus("s_m3x5",   1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
        applyStimulus("u_m3x5",   1'b0, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 1'b0, 1'b0);
        applyStimulus("s_minsq",  1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
        applyStimulus("s_minx1",  1'b1, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0);

        // Handshake: start/mthi/mtlo ignored while busy, then back-to-back.
        applyStimulus("ignore",   1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b1, 1'b0);
        applyStimulus("b2b",      1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000000, 32'h00000004, 1'b0, 1'b0);

        // mthi/mtlo together with start: the product overwrites the write.
        applyStimulus("wr_start", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1);

        // Random sweep against the reference model and the low-word product.
        for (int n = 0; n < 1000; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rs  = 1'($urandom_range(0, 1));
            rp  = refProd(rs, ra, rb);
            rlo = ra * rb;
            applyStimulus("rand", rs, ra, rb, rp[63:32], rlo, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mult_hilo_seq.md
Name: mult_hilo_seq

Overview:
Sequential multiply unit downstream of the combinational 32-bit ALU multiplier. That multiplier returns only the low word of the product. This block computes the full 2*WIDTH-bit signed or unsigned product with an iterative shift-add datapath. It holds the result in architectural HI/LO registers, and the control unit stalls on busy and reads HI/LO for mfhi/mflo.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a multiply; sampled only in IDLE
is_signed  input  1  1 = two's-complement operands (mult); 0 = unsigned (multu); latched with start
a  input  WIDTH  multiplicand; latched with start
b  input  WIDTH  multiplier; latched with start
mthi  input  1  write hi_wdata into HI (IDLE only)
mtlo  input  1  write lo_wdata into LO (IDLE only)
hi_wdata  input  WIDTH  data for mthi
lo_wdata  input  WIDTH  data for mtlo
busy  output  1  high whenever state != IDLE; control unit stalls on it
done  output  1  one-cycle pulse when HI/LO are updated with a product
hi  output  WIDTH  HI register (upper product word)
lo  output  WIDTH  LO register (lower product word)

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0, accumulator=0. Reset mid-operation aborts; no partial result reaches HI/LO.
- States: IDLE -> BUSY -> FINISH -> IDLE.
- IDLE:
  - start=1: latch |a|, |b| (magnitudes if is_signed, raw if not), latch sign = is_signed & (a[MSB]^b[MSB]), clear 2*WIDTH accumulator, counter=0, go to BUSY.
  - Magnitude of the most negative value (0x80000000) is 0x80000000 treated as unsigned; no overflow.
- BUSY: each cycle, if multiplier LSB=1, add multiplicand into the upper half of the accumulator with carry out; shift the accumulator/multiplier right by one; counter++. After WIDTH iterations (counter==WIDTH-1 this cycle), go to FINISH.
- FINISH: product = sign ? two's-complement negate(accumulator) : accumulator; hi<=product[2W-1:W], lo<=product[W-1:0]; done=1 this cycle only; next state IDLE.
- Latency (WIDTH=32): start sampled at edge 0; BUSY occupies cycles 1..32; FINISH in cycle 33 with done=1 and HI/LO valid after that edge; busy=1 in cycles 1..33. Back-to-back start is legal in the cycle after done.
- start while busy: ignored, no queueing. Operands may change freely after the start cycle.
- mthi/mtlo: honoured only in IDLE; ignored while busy. Both may be asserted in the same cycle.
- mthi/mtlo with start in the same IDLE cycle: write takes effect now and is overwritten at FINISH.
- lo always equals the low word the combinational multiplier produces for the same operands; signedness does not affect the low word.
- hi/lo hold their value except on FINISH, mthi/mtlo, or reset.

Test Plan:
- Reset mid-op: start a=7,b=9, assert reset at cycle 10 -> busy=0 next cycle, hi=lo=0, done never pulses; new start afterwards completes normally.
- Unsigned max: is_signed=0, a=b=0xFFFFFFFF -> done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001, busy high cycles 1..33.
- Signed mixed: is_signed=1, a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Same operands with is_signed=0 -> hi=0x00000004, lo=0xFFFFFFF1.
- Signed corner: is_signed=1, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Handshake: start pulsed again at cycles 5 and 20 of an op with different operands -> ignored, result matches the first operands. start in the cycle after done -> second result after another 33 cycles.
- mthi/mtlo: in IDLE, mthi=1 hi_wdata=0x12345678 and mtlo=1 lo_wdata=0x9ABCDEF0 -> hi/lo updated next edge. Same writes while busy -> no effect. Random 1000-vector sweep: lo matches the combinational multiplier's output and {hi,lo} matches the 64-bit reference model.
